// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32I ID stage: opcodes, decoder fields and ALU control.
// Consumers of DECODE_ILLEGAL_TRAP_EN rely on the opcode set defined here.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

endpackage

// File: rtl/register_file.sv
// Architectural 2R1W register file with x0 hardwired to zero.
// Reads see a same-cycle writeback through a write-through bypass.
module register_file #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [$clog2(NREGS)-1:0] addr1_i,
    input  logic [$clog2(NREGS)-1:0] addr2_i,
    input  logic                     we_i,
    input  logic [$clog2(NREGS)-1:0] wa_i,
    input  logic [XLEN-1:0]          wd_i,
    output logic [XLEN-1:0]          rd1_o,
    output logic [XLEN-1:0]          rd2_o
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic            wr_en;

    assign wr_en = we_i && (wa_i != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '{default: '0};
        end else if (wr_en) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    // Bypass lets the ID stage see the value WB commits on the same edge.
    always_comb begin
        rd1_o = '0;
        if (addr1_i != '0) begin
            rd1_o = (wr_en && (wa_i == addr1_i)) ? wd_i : regs_q[addr1_i];
        end
    end

    always_comb begin
        rd2_o = '0;
        if (addr2_i != '0) begin
            rd2_o = (wr_en && (wa_i == addr2_i)) ? wd_i : regs_q[addr2_i];
        end
    end

endmodule

// File: rtl/decode_cycle.sv
// RV32I ID stage: decode, register read, immediate extend, ID/EX pipeline register.
// Define DECODE_ILLEGAL_TRAP_EN to add the registered IllegalE flag.
module decode_cycle
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              InstrD,
    input  logic [XLEN-1:0]          PCD,
    input  logic [XLEN-1:0]          PcPlus4D,
    input  logic                     RegWriteW,
    input  logic [$clog2(NREGS)-1:0] RDW,
    input  logic [XLEN-1:0]          ResultW,
    input  logic                     FlushE,
    output logic                     RegWriteE,
    output logic [1:0]               ResultSrcE,
    output logic                     MemWriteE,
    output logic                     JumpE,
    output logic                     BranchE,
    output logic [2:0]               ALUControlE,
    output logic                     ALUSrcE,
    output logic [XLEN-1:0]          RD1E,
    output logic [XLEN-1:0]          RD2E,
    output logic [XLEN-1:0]          ImmExtE,
    output logic [4:0]               RdE,
    output logic [4:0]               Rs1E,
    output logic [4:0]               Rs2E,
    output logic [XLEN-1:0]          PCE,
`ifdef DECODE_ILLEGAL_TRAP_EN
    output logic                     IllegalE,
`endif
    output logic [XLEN-1:0]          PCPlus4E
);

    typedef struct packed {
        logic            reg_write;
        logic [1:0]      result_src;
        logic            mem_write;
        logic            jump;
        logic            branch;
        logic [2:0]      alu_ctrl;
        logic            alu_src;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm_ext;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
`ifdef DECODE_ILLEGAL_TRAP_EN
        logic            illegal;
`endif
    } idex_t;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            reg_write;
    logic            alu_src;
    logic            mem_write;
    logic            branch;
    logic            jump;
    result_src_e     result_src;
    imm_src_e        imm_src;
    alu_op_e         alu_op;
    alu_ctrl_e       alu_ctrl;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    idex_t           idex_d;
    idex_t           idex_q;

    assign opcode = InstrD[6:0];
    assign funct3 = InstrD[14:12];

    register_file #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_register_file (
        .clk     (clk),
        .rst_n   (rst),
        .addr1_i (InstrD[19:15]),
        .addr2_i (InstrD[24:20]),
        .we_i    (RegWriteW),
        .wa_i    (RDW),
        .wd_i    (ResultW),
        .rd1_o   (rd1),
        .rd2_o   (rd2)
    );

    always_comb begin
        reg_write  = 1'b0;
        imm_src    = IMM_I;
        alu_src    = 1'b0;
        mem_write  = 1'b0;
        result_src = RES_ALU;
        branch     = 1'b0;
        alu_op     = ALUOP_ADD;
        jump       = 1'b0;
        case (opcode)
            OP_LOAD: begin
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                result_src = RES_MEM;
            end
            OP_STORE: begin
                imm_src   = IMM_S;
                alu_src   = 1'b1;
                mem_write = 1'b1;
            end
            OP_RTYPE: begin
                reg_write = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            OP_BRANCH: begin
                imm_src = IMM_B;
                branch  = 1'b1;
                alu_op  = ALUOP_SUB;
            end
            OP_IALU: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            OP_JAL: begin
                reg_write  = 1'b1;
                imm_src    = IMM_J;
                result_src = RES_PC4;
                jump       = 1'b1;
            end
            default: ;
        endcase
    end

    // Only R-type uses funct7[5] to pick sub; addi with imm[10] set stays add.
    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_ctrl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_ctrl = (InstrD[5] && InstrD[30]) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_ctrl = ALU_SLT;
                    3'b110:  alu_ctrl = ALU_OR;
                    3'b111:  alu_ctrl = ALU_AND;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

    always_comb begin
        imm_ext = '0;
        case (imm_src)
            IMM_I: imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
            IMM_S: imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            IMM_B: imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
            IMM_J: imm_ext = {{(XLEN-20){InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
            default: imm_ext = '0;
        endcase
    end

    always_comb begin
        idex_d            = '0;
        idex_d.reg_write  = reg_write;
        idex_d.result_src = result_src;
        idex_d.mem_write  = mem_write;
        idex_d.jump       = jump;
        idex_d.branch     = branch;
        idex_d.alu_ctrl   = alu_ctrl;
        idex_d.alu_src    = alu_src;
        idex_d.rd1        = rd1;
        idex_d.rd2        = rd2;
        idex_d.imm_ext    = imm_ext;
        idex_d.rd         = InstrD[11:7];
        idex_d.rs1        = InstrD[19:15];
        idex_d.rs2        = InstrD[24:20];
        idex_d.pc         = PCD;
        idex_d.pc_plus4   = PcPlus4D;
`ifdef DECODE_ILLEGAL_TRAP_EN
        idex_d.illegal    = !(opcode inside {OP_LOAD, OP_STORE, OP_RTYPE, OP_BRANCH, OP_IALU, OP_JAL})
                            && (InstrD != '0);
`endif
        if (FlushE) begin
            idex_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign RegWriteE   = idex_q.reg_write;
    assign ResultSrcE  = idex_q.result_src;
    assign MemWriteE   = idex_q.mem_write;
    assign JumpE       = idex_q.jump;
    assign BranchE     = idex_q.branch;
    assign ALUControlE = idex_q.alu_ctrl;
    assign ALUSrcE     = idex_q.alu_src;
    assign RD1E        = idex_q.rd1;
    assign RD2E        = idex_q.rd2;
    assign ImmExtE     = idex_q.imm_ext;
    assign RdE         = idex_q.rd;
    assign Rs1E        = idex_q.rs1;
    assign Rs2E        = idex_q.rs2;
    assign PCE         = idex_q.pc;
    assign PCPlus4E    = idex_q.pc_plus4;
`ifdef DECODE_ILLEGAL_TRAP_EN
    assign IllegalE    = idex_q.illegal;
`endif

endmodule

// File: tb/tb_decode_cycle.sv
// Directed testbench for decode_cycle with hand-computed expectations.
// Control vector order: {RegWrite, ResultSrc[1:0], MemWrite, Jump, Branch, ALUControl[2:0], ALUSrc}.
module tb_decode_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PcPlus4D;
    logic        RegWriteW;
    logic [4:0]  RDW;
    logic [31:0] ResultW;
    logic        FlushE;
    logic        RegWriteE;
    logic [1:0]  ResultSrcE;
    logic        MemWriteE;
    logic        JumpE;
    logic        BranchE;
    logic [2:0]  ALUControlE;
    logic        ALUSrcE;
    logic [31:0] RD1E;
    logic [31:0] RD2E;
    logic [31:0] ImmExtE;
    logic [4:0]  RdE;
    logic [4:0]  Rs1E;
    logic [4:0]  Rs2E;
    logic [31:0] PCE;
    logic [31:0] PCPlus4E;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic        IllegalE;
`endif

    logic [9:0]  ctrl_e;
    int          checks   = 0;
    int          failures = 0;

    assign ctrl_e = {RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE, ALUSrcE};

    decode_cycle dut (
        .clk         (clk),
        .rst         (rst),
        .InstrD      (InstrD),
        .PCD         (PCD),
        .PcPlus4D    (PcPlus4D),
        .RegWriteW   (RegWriteW),
        .RDW         (RDW),
        .ResultW     (ResultW),
        .FlushE      (FlushE),
        .RegWriteE   (RegWriteE),
        .ResultSrcE  (ResultSrcE),
        .MemWriteE   (MemWriteE),
        .JumpE       (JumpE),
        .BranchE     (BranchE),
        .ALUControlE (ALUControlE),
        .ALUSrcE     (ALUSrcE),
        .RD1E        (RD1E),
        .RD2E        (RD2E),
        .ImmExtE     (ImmExtE),
        .RdE         (RdE),
        .Rs1E        (Rs1E),
        .Rs2E        (Rs2E),
        .PCE         (PCE),
`ifdef DECODE_ILLEGAL_TRAP_EN
        .IllegalE    (IllegalE),
`endif
        .PCPlus4E    (PCPlus4E)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctrl"}, 32'(ctrl_e), 32'd0);
        chk({tag, "_rd1"},  RD1E, 32'd0);
        chk({tag, "_rd2"},  RD2E, 32'd0);
        chk({tag, "_imm"},  ImmExtE, 32'd0);
        chk({tag, "_regs"}, 32'({RdE, Rs1E, Rs2E}), 32'd0);
        chk({tag, "_pc"},   PCE, 32'd0);
        chk({tag, "_pc4"},  PCPlus4E, 32'd0);
    endtask

    initial begin
        rst       = 1'b0;
        InstrD    = 32'h0050_0093;   // addi x1, x0, 5
        PCD       = 32'h0000_0100;
        PcPlus4D  = 32'h0000_0104;
        RegWriteW = 1'b0;
        RDW       = 5'd0;
        ResultW   = 32'd0;
        FlushE    = 1'b0;

        @(negedge clk);
        chk_all_zero("reset");
        step();
        chk_all_zero("reset_held");

        rst = 1'b1;
        step();
        chk("addi_ctrl", 32'(ctrl_e), 32'(10'b1_00_0_0_0_000_1));
        chk("addi_imm",  ImmExtE, 32'd5);
        chk("addi_rd",   32'(RdE), 32'd1);
        chk("addi_rd1",  RD1E, 32'd0);
        chk("addi_pc",   PCE, 32'h0000_0100);
        chk("addi_pc4",  PCPlus4E, 32'h0000_0104);

        // Write x2 through WB, then read it back as the sw data operand
        RegWriteW = 1'b1; RDW = 5'd2; ResultW = 32'hDEAD_BEEF;
        InstrD = 32'h0000_0000; PCD = 32'h0000_0104; PcPlus4D = 32'h0000_0108;
        step();
        chk("nop_ctrl", 32'(ctrl_e), 32'd0);
        RegWriteW = 1'b0;
        InstrD = 32'h0020_2423;      // sw x2, 8(x0)
        step();
        chk("sw_ctrl", 32'(ctrl_e), 32'(10'b0_00_1_0_0_000_1));
        chk("sw_rd2",  RD2E, 32'hDEAD_BEEF);
        chk("sw_imm",  ImmExtE, 32'd8);
        chk("sw_rs",   32'({Rs1E, Rs2E}), 32'({5'd0, 5'd2}));
        chk("sw_pc",   PCE, 32'h0000_0104);

        // Same-cycle writeback must be visible to the read
        RegWriteW = 1'b1; RDW = 5'd2; ResultW = 32'h1234_5678;
        step();
        chk("bypass_rd2", RD2E, 32'h1234_5678);
        RegWriteW = 1'b0; ResultW = 32'h0;
        step();
        chk("commit_rd2", RD2E, 32'h1234_5678);

        // x0 writes are dropped, including on the bypass path
        RegWriteW = 1'b1; RDW = 5'd0; ResultW = 32'hFFFF_FFFF;
        InstrD = 32'h0050_0093;
        step();
        chk("x0_bypass_rd1", RD1E, 32'd0);
        RegWriteW = 1'b0;
        step();
        chk("x0_rd1", RD1E, 32'd0);

        InstrD = 32'hFE00_0EE3;      // beq x0, x0, -4
        step();
        chk("beq_ctrl", 32'(ctrl_e), 32'(10'b0_00_0_0_1_001_0));
        chk("beq_imm",  ImmExtE, 32'hFFFF_FFFC);

        InstrD = 32'h4020_81B3;      // sub x3, x1, x2
        step();
        chk("sub_ctrl", 32'(ctrl_e), 32'(10'b1_00_0_0_0_001_0));
        chk("sub_rd2",  RD2E, 32'h1234_5678);
        chk("sub_rd",   32'(RdE), 32'd3);

        InstrD = 32'h0020_F1B3;      // and x3, x1, x2
        step();
        chk("and_ctrl", 32'(ctrl_e), 32'(10'b1_00_0_0_0_010_0));

        InstrD = 32'h0020_E1B3;      // or x3, x1, x2
        step();
        chk("or_ctrl", 32'(ctrl_e), 32'(10'b1_00_0_0_0_011_0));

        InstrD = 32'hFFF0_A193;      // slti x3, x1, -1
        step();
        chk("slti_ctrl", 32'(ctrl_e), 32'(10'b1_00_0_0_0_101_1));
        chk("slti_imm",  ImmExtE, 32'hFFFF_FFFF);

        InstrD = 32'h4000_0093;      // addi x1, x0, 0x400 (bit 30 set, still add)
        step();
        chk("addi400_ctrl", 32'(ctrl_e), 32'(10'b1_00_0_0_0_000_1));
        chk("addi400_imm",  ImmExtE, 32'h0000_0400);

        InstrD = 32'h0041_2203;      // lw x4, 4(x2)
        step();
        chk("lw_ctrl", 32'(ctrl_e), 32'(10'b1_01_0_0_0_000_1));
        chk("lw_rd1",  RD1E, 32'h1234_5678);
        chk("lw_imm",  ImmExtE, 32'd4);

        InstrD = 32'h0080_00EF;      // jal x1, +8
        step();
        chk("jal_ctrl", 32'(ctrl_e), 32'(10'b1_10_0_1_0_000_0));
        chk("jal_imm",  ImmExtE, 32'd8);

        InstrD = 32'h0000_007F;      // unknown opcode
        step();
        chk("unk_ctrl", 32'(ctrl_e), 32'd0);
`ifdef DECODE_ILLEGAL_TRAP_EN
        chk("unk_illegal", 32'(IllegalE), 32'd1);
`endif

        // Flush bubbles ID/EX but the WB write still lands
        FlushE = 1'b1; InstrD = 32'h0050_0093;
        RegWriteW = 1'b1; RDW = 5'd5; ResultW = 32'hA5A5_A5A5;
        step();
        chk_all_zero("flush");
`ifdef DECODE_ILLEGAL_TRAP_EN
        chk("flush_illegal", 32'(IllegalE), 32'd0);
`endif
        FlushE = 1'b0; RegWriteW = 1'b0;
        InstrD = 32'h0002_8313;      // addi x6, x5, 0
        step();
        chk("flushwr_rd1",  RD1E, 32'hA5A5_A5A5);
        chk("flushwr_ctrl", 32'(ctrl_e), 32'(10'b1_00_0_0_0_000_1));

`ifdef DECODE_ILLEGAL_TRAP_EN
        InstrD = 32'h0000_0000;
        step();
        chk("zero_illegal", 32'(IllegalE), 32'd0);
        InstrD = 32'h0002_8313;
        step();
`endif

        // Async reset mid-stream clears ID/EX and the register file
        rst = 1'b0;
        #1;
        chk_all_zero("async_rst");
        #1;
        rst = 1'b1;
        InstrD = 32'h0020_2423;      // sw x2, 8(x0)
        step();
        chk("post_rst_ctrl", 32'(ctrl_e), 32'(10'b0_00_1_0_0_000_1));
        chk("post_rst_rd2",  RD2E, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_cycle.md
Name: decode_cycle

Overview:
ID stage of the 5-stage RISC-V pipeline, directly downstream of the fetch stage.
- Consumes InstrD/PCD/PcPlus4D from the IF/ID register.
- Decodes control, reads the 32x32 register file, sign-extends the immediate, and registers everything into the ID/EX register.
- Owns the architectural register file; writeback drives its write port.

Parameters:
- XLEN, 32, data/address width
- NREGS, 32, register count (x0 hardwired to zero)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- InstrD  in  32  instruction from IF/ID
- PCD  in  32  PC of InstrD
- PcPlus4D  in  32  PCD+4
- RegWriteW  in  1  writeback enable
- RDW  in  5  writeback destination
- ResultW  in  32  writeback data
- FlushE  in  1  synchronous bubble insert into ID/EX
- RegWriteE  out  1  registered control
- ResultSrcE  out  2  00 ALU, 01 mem, 10 PC+4
- MemWriteE  out  1  registered control
- JumpE  out  1  registered control
- BranchE  out  1  registered control
- ALUControlE  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- ALUSrcE  out  1  1 = immediate operand
- RD1E  out  32  registered rs1 data
- RD2E  out  32  registered rs2 data
- ImmExtE  out  32  registered extended immediate
- RdE  out  5  registered rd
- Rs1E  out  5  registered rs1
- Rs2E  out  5  registered rs2
- PCE  out  32  registered PCD
- PCPlus4E  out  32  registered PcPlus4D

Behaviour:
- Reset (rst=0, async): all ID/EX outputs 0. All 32 registers cleared to 0.
- Latency: one cycle, ID to E outputs.
- Register file write:
  - Occurs at the rising edge when RegWriteW=1 and RDW!=0.
  - Writes to x0 are ignored; a read of x0 always returns 0.
- Register file read:
  - Combinational on InstrD[19:15] and InstrD[24:20].
  - Write-through bypass: if RegWriteW=1, RDW!=0 and RDW equals the read address, the read returns ResultW in the same cycle. This resolves the WB/ID same-cycle hazard.
- Main decoder (opcode to RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp, Jump):
  - 0000011 lw: 1, I, 1, 0, 01, 0, 00, 0
  - 0100011 sw: 0, S, 1, 1, xx→00, 0, 00, 0
  - 0110011 R-type: 1, -, 0, 0, 00, 0, 10, 0
  - 1100011 beq: 0, B, 0, 0, 00, 1, 01, 0
  - 0010011 I-ALU: 1, I, 1, 0, 00, 0, 10, 0
  - 1101111 jal: 1, J, -, 0, 10, 0, 00, 1
  - Any other opcode: all controls 0 (NOP).
- ALU decoder:
  - ALUOp 00 → add; ALUOp 01 → sub.
  - ALUOp 10, funct3 000 → sub if {op[5],funct7[5]}=11, else add.
  - ALUOp 10, funct3 010 → slt; 110 → or; 111 → and; other funct3 → add.
- Immediate extend (sign bit InstrD[31]):
  - I: imm[11:0]
  - S: {[31:25],[11:7]}
  - B: {[31],[7],[30:25],[11:8],0}
  - J: {[31],[19:12],[20],[30:21],0}
- FlushE=1 at an edge: ID/EX loads all zeros (NOP bubble) regardless of InstrD. Register-file writes still occur that edge.
- Reset deasserted mid-stream: the first edge after release captures the current InstrD normally.

Optional Feature:
- Macro DECODE_ILLEGAL_TRAP_EN.
- With the macro defined:
  - Adds output IllegalE (1 bit), registered.
  - IllegalE=1 when the opcode is not in the decoded set and InstrD!=0.
  - Cleared by reset and by FlushE.
- Without the macro: the port is absent; unknown opcodes silently decode as NOP.

Decomposition:
- Package riscv_pkg holds:
  - opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_BRANCH, OP_IALU, OP_JAL)
  - ALUControl encodings
  - ImmSrc encodings
  - ResultSrc encodings
- One natural sub-module: register_file, holding the array, async-low reset, write port and write-through bypass.
- Control and immediate decoding stay inline.

Test Plan:
- Reset: rst=0 with InstrD=0x00500093 → all E outputs 0. After release and one edge: RegWriteE=1, ALUSrcE=1, ImmExtE=5, RdE=1, ALUControlE=000.
- Write then read: write x2=0xDEADBEEF via WB, then InstrD=0x00202423 (sw x2,8(x0)) → MemWriteE=1, RD2E=0xDEADBEEF, ImmExtE=8, RegWriteE=0.
- Bypass: RegWriteW=1, RDW=2, ResultW=0x12345678 in the same cycle as InstrD=0x00202423 → RD2E=0x12345678 after the edge.
- x0 protection: RegWriteW=1, RDW=0, ResultW=0xFFFFFFFF, then read x0 → RD1E=0.
- Branch immediate: InstrD=0xFE000EE3 (beq x0,x0,-4) → BranchE=1, ALUControlE=001, ImmExtE=0xFFFFFFFC.
- Flush: FlushE=1 with InstrD=0x00500093 → all controls 0 after the edge. With DECODE_ILLEGAL_TRAP_EN, InstrD=0x0000007F → IllegalE=1.
